// File: rtl/fifo_4096_pkg.sv
// Shared constants and types for the 4096 x 8 dual-port buffer.
// The buffer is addressed directly by external pointers and keeps no occupancy state.
package fifo_4096_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 12;
   localparam int DEPTH      = 4096;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/fifo_4096_ram_core.sv
// Simple dual-port synchronous RAM, read-first, no reset, so it maps onto block RAM.
// The read register loads only when re_i is high and holds its value otherwise.
module fifo_4096_ram_core
   import fifo_4096_pkg::*;
#(
   parameter int RAM_DW = DATA_WIDTH,
   parameter int RAM_AW = ADDR_WIDTH
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [RAM_AW-1:0] wr_addr_i,
   input  logic [RAM_DW-1:0] wr_data_i,
   input  logic              re_i,
   input  logic [RAM_AW-1:0] rd_addr_i,
   output logic [RAM_DW-1:0] rd_data_o
);

   logic [RAM_DW-1:0] mem_q [2**RAM_AW];
   logic [RAM_DW-1:0] rd_data_q;

   // Both ports update in one process, so a same-address read returns the old word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (re_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_4096_dp.sv
// 4096 x 8 buffer with independent write/read addresses, registered read data and
// per-entry valid bits so that locations not written since reset read back as zero.
module fifo_4096_dp
   import fifo_4096_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] wr_address,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] data_out
);

   // write and read are single-cycle enables with no back-pressure: the block accepts
   // every request at the edge that samples it, except during reset when both are dropped.
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             hit_q, hit_d;
   logic             ram_we, ram_re;
   data_t            ram_rd_data;

   assign ram_we = write & ~rst;
   assign ram_re = read & ~rst;

   fifo_4096_ram_core #(
      .RAM_DW(DATA_WIDTH),
      .RAM_AW(ADDR_WIDTH)
   ) u_ram (
      .clk_i    (clk),
      .we_i     (ram_we),
      .wr_addr_i(wr_address),
      .wr_data_i(data_in),
      .re_i     (ram_re),
      .rd_addr_i(rd_address),
      .rd_data_o(ram_rd_data)
   );

   // hit_q samples the pre-write valid bit, matching the RAM's read-first behaviour.
   always_comb begin
      valid_d = valid_q;
      hit_d   = hit_q;
      if (write) begin
         valid_d[wr_address] = 1'b1;
      end
      if (read) begin
         hit_d = valid_q[rd_address];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         hit_q   <= hit_d;
      end
   end

   // A cleared hit_q forces zero, which also gives data_out its reset value.
   assign data_out = hit_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_fifo_4096_dp.sv
// Directed bench for fifo_4096_dp: reset, read-back, collision, streaming,
// full sweep with pointer wrap and reset during a write.
module tb_fifo_4096_dp;

   logic        clk;
   logic        rst;
   logic [7:0]  data_in;
   logic [11:0] wr_address;
   logic        write;
   logic [11:0] rd_address;
   logic        read;
   logic [7:0]  data_out;

   int vectors;
   int miscompares;

   fifo_4096_dp dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .wr_address(wr_address),
      .write     (write),
      .rd_address(rd_address),
      .read      (read),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic do_write(input logic [11:0] a, input logic [7:0] d);
      write      = 1'b1;
      wr_address = a;
      data_in    = d;
      read       = 1'b0;
      tick();
      idle();
   endtask

   task automatic do_read_check(input string name, input logic [11:0] a, input logic [7:0] exp);
      read       = 1'b1;
      rd_address = a;
      write      = 1'b0;
      tick();
      idle();
      vectors++;
      if (data_out !== exp) begin
         miscompares++;
         $display("FAIL %s addr=%03h got=%02h expected=%02h", name, a, data_out, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if (data_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_value got=%02h expected=00", data_out);
      end
      do_read_check("reset_read_0", 12'h000, 8'h00);
      do_read_check("reset_read_1", 12'h001, 8'h00);
      do_read_check("reset_read_fff", 12'hFFF, 8'h00);
   endtask

   task automatic test_write_read();
      do_write(12'h000, 8'hA5);
      do_write(12'h7FF, 8'h3C);
      do_write(12'hFFF, 8'hFF);
      do_read_check("wr_rd_000", 12'h000, 8'hA5);
      do_read_check("wr_rd_7ff", 12'h7FF, 8'h3C);
      do_read_check("wr_rd_fff", 12'hFFF, 8'hFF);
      // Change the read address while read is low: output must not move.
      rd_address = 12'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (data_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL hold cycle=%0d got=%02h expected=ff", i, data_out);
         end
      end
   endtask

   task automatic test_collision();
      do_write(12'h010, 8'h11);
      write      = 1'b1;
      wr_address = 12'h010;
      data_in    = 8'h22;
      read       = 1'b1;
      rd_address = 12'h010;
      tick();
      idle();
      vectors++;
      if (data_out !== 8'h11) begin
         miscompares++;
         $display("FAIL collision_old got=%02h expected=11", data_out);
      end
      do_read_check("collision_new", 12'h010, 8'h22);
      // Collision on a never-written entry returns zero.
      write      = 1'b1;
      wr_address = 12'h123;
      data_in    = 8'h99;
      read       = 1'b1;
      rd_address = 12'h123;
      tick();
      idle();
      vectors++;
      if (data_out !== 8'h00) begin
         miscompares++;
         $display("FAIL collision_unwritten got=%02h expected=00", data_out);
      end
      do_read_check("collision_unwritten_new", 12'h123, 8'h99);
      do_write(12'h124, 8'h01);
      do_write(12'h124, 8'h02);
      do_read_check("last_write_wins", 12'h124, 8'h02);
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 256; i++) begin
         write      = 1'b1;
         wr_address = 12'(i);
         data_in    = 8'(i);
         read       = (i > 0);
         rd_address = 12'(i - 1);
         tick();
         if (i > 0) begin
            vectors++;
            if (data_out !== 8'(i - 1)) begin
               miscompares++;
               $display("FAIL stream idx=%0d got=%02h expected=%02h", i - 1, data_out, 8'(i - 1));
            end
         end
      end
      idle();
      do_read_check("stream_last", 12'd255, 8'd255);
   endtask

   task automatic test_sweep();
      logic [11:0] wp;
      logic [11:0] a;
      logic [7:0]  exp;
      wp = 12'h000;
      for (int i = 0; i < 4096; i++) begin
         write      = 1'b1;
         wr_address = wp;
         data_in    = wp[7:0];
         tick();
         wp = wp + 12'd1;
      end
      // wp has wrapped from 4095 back to 0.
      write      = 1'b1;
      wr_address = wp;
      data_in    = 8'h5A;
      tick();
      idle();
      for (int i = 0; i < 4096; i++) begin
         a   = 12'(i);
         exp = (i == 0) ? 8'h5A : a[7:0];
         do_read_check("sweep", a, exp);
      end
   endtask

   task automatic test_reset_mid();
      // In the reset cycle both the write and a read of a valid entry are dropped.
      write      = 1'b1;
      wr_address = 12'h020;
      data_in    = 8'h77;
      read       = 1'b1;
      rd_address = 12'h7FF;
      rst        = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      vectors++;
      if (data_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_mid_out got=%02h expected=00", data_out);
      end
      do_read_check("reset_mid_020", 12'h020, 8'h00);
      do_read_check("reset_mid_7ff", 12'h7FF, 8'h00);
      do_read_check("reset_mid_000", 12'h000, 8'h00);
      do_write(12'h020, 8'h33);
      do_read_check("reset_mid_rewrite", 12'h020, 8'h33);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      data_in     = 8'h00;
      wr_address  = 12'h000;
      rd_address  = 12'h000;
      write       = 1'b0;
      read        = 1'b0;
      test_reset();
      test_write_read();
      test_collision();
      test_streaming();
      test_sweep();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_4096_dp.md
Name: fifo_4096_dp

Overview:
- 4096-entry × 8-bit buffer memory with a write port and a read port, each addressed independently.
- Read and write pointers are owned by the surrounding producer/consumer logic (the fifo_if testbench drivers), not by this block.
- Single clock domain. Registered read data. Per-entry valid tracking so unwritten locations read as zero after reset.

Parameters:
- DATA_WIDTH, 8: width of data_in and data_out.
- ADDR_WIDTH, 12: width of wr_address and rd_address.
- DEPTH, 4096: number of entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- wr_address  input  ADDR_WIDTH  write location.
- write  input  1  write enable.
- rd_address  input  ADDR_WIDTH  read location.
- read  input  1  read enable.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - data_out <= 0.
  - All 4096 entry-valid bits cleared.
  - Array contents need not be cleared.
  - read and write are ignored in that cycle.
- Write: write=1 at an edge -> mem[wr_address] <= data_in and valid[wr_address] <= 1. Applies to all addresses 0..4095 with no wrap logic; the address width covers the full depth exactly.
- Read: read=1 at an edge -> data_out <= valid[rd_address] ? mem[rd_address] : 0. Latency is 1 cycle: data_out is valid after the edge that sampled read.
- read=0: data_out holds its previous value.
- Simultaneous read and write, same address: read-first. data_out gets the pre-write contents (0 if the entry was previously unwritten); the new data is visible on the next read.
- Simultaneous read and write, different addresses: fully independent.
- Repeated writes to one address: last write wins.
- Reset asserted mid-stream: the current read/write is discarded. Every entry reads 0 until rewritten.
- No full/empty flags and no overflow/underflow detection; pointer management and occupancy are external.
- X/unknown on read, write or rst is not a supported condition.
- Storage must infer block RAM. The valid bits are a separate flop vector so reset can clear them in one cycle.

Decomposition:
- Package fifo_4096_pkg:
  - DATA_WIDTH, ADDR_WIDTH, DEPTH constants.
  - data_t = logic [DATA_WIDTH-1:0], addr_t = logic [ADDR_WIDTH-1:0].
- Sub-module fifo_4096_ram_core:
  - Plain simple-dual-port synchronous RAM, read-first, no reset, inferrable.
  - The top level adds the valid-bit vector, the zero-masking mux on read data, and the data_out reset.

Test Plan:
- Reset then read: rst 1 for 2 cycles, then read addresses 0, 1, 4095 -> data_out = 0x00 each, one cycle after each read.
- Write/read back: write 0xA5@0x000, 0x3C@0x7FF, 0xFF@0xFFF; then read the same addresses -> 0xA5, 0x3C, 0xFF with 1-cycle latency. data_out holds 0xFF while read=0.
- Same-address collision: 0x11 already at 0x010; in one cycle write 0x22@0x010 with read@0x010 -> data_out = 0x11; next-cycle read -> 0x22.
- Streaming order: write 0..255 to addresses 0..255 while reading one address behind the write pointer each cycle -> data_out sequence 0,1,...,255 in order with no gaps.
- Full sweep and wrap: write all 4096 entries with data = addr[7:0], with the external pointer wrapping from 4095 to 0. Overwrite 0x000 with 0x5A; read all -> each entry = addr[7:0] except entry 0 = 0x5A.
- Reset mid-operation: after the writes above, assert rst in the same cycle as write 0x77@0x020 -> the write is dropped. A later read of 0x020 and 0x7FF returns 0x00.
